// File: rtl/regfile_wb_arb_if.sv
// Writeback bus between the two result producers (ALU, load unit) and the
// register-file write port.
interface regfile_wb_arb_if;
    logic        a_valid;
    logic [4:0]  a_sel;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_sel;
    logic [31:0] b_data;
    logic        b_ready;
    logic        wEn;
    logic [4:0]  write_sel;
    logic [31:0] write_data;
    logic        init_done;

    modport slave (
        input  a_valid, a_sel, a_data, b_valid, b_sel, b_data,
        output a_ready, b_ready, wEn, write_sel, write_data, init_done
    );

    modport master (
        output a_valid, a_sel, a_data, b_valid, b_sel, b_data,
        input  a_ready, b_ready, wEn, write_sel, write_data, init_done
    );
endinterface

// File: rtl/regfile_wb_arb.sv
// Two-requester round-robin writeback arbiter feeding a registered write port,
// with an optional post-reset zero-fill sweep of x1..x31.
module regfile_wb_arb #(
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    regfile_wb_arb_if.slave  wb
);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;
    localparam state_t RST_STATE = INIT_CLEAR ? S_INIT : S_RUN;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        prio_q, prio_d;
    logic        wen_q, wen_d;
    logic [4:0]  sel_q, sel_d;
    logic [31:0] data_q, data_d;

    logic        a_take, b_take;

    // Grant decision feeding the registers; reset only gates the visible handshake.
    always_comb begin
        a_take = (state_q == S_RUN) && wb.a_valid && (!wb.b_valid || !prio_q);
        b_take = (state_q == S_RUN) && wb.b_valid && (!wb.a_valid ||  prio_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= RST_STATE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && idx_q == 5'd31) state_d = S_RUN;
    end

    always_comb begin
        wb.a_ready   = reset && a_take;
        wb.b_ready   = reset && b_take;
        wb.init_done = reset && (state_q == S_RUN);
        wb.wEn        = wen_q;
        wb.write_sel  = sel_q;
        wb.write_data = data_q;
    end

    always_comb begin
        idx_d  = idx_q;
        prio_d = prio_q;
        wen_d  = 1'b0;
        sel_d  = sel_q;
        data_d = data_q;
        if (state_q == S_INIT) begin
            wen_d  = 1'b1;
            sel_d  = idx_q;
            data_d = 32'd0;
            idx_d  = idx_q + 5'd1;
        end else if (a_take) begin
            // x0 writes are accepted but never reach the register file
            wen_d  = |wb.a_sel;
            sel_d  = wb.a_sel;
            data_d = wb.a_data;
            prio_d = 1'b1;
        end else if (b_take) begin
            wen_d  = |wb.b_sel;
            sel_d  = wb.b_sel;
            data_d = wb.b_data;
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q  <= 5'd1;
            prio_q <= 1'b0;
            wen_q  <= 1'b0;
            sel_q  <= 5'd0;
            data_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            prio_q <= prio_d;
            wen_q  <= wen_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomised + directed scoreboard bench for regfile_wb_arb; two instances
// cover INIT_CLEAR=1 and INIT_CLEAR=0 from shared stimulus.
module tb_regfile_wb_arb;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        av, bv;
  logic [4:0]  as_, bs;
  logic [31:0] ad, bd;
  bit          use0 = 1'b0;

  regfile_wb_arb_if if1();
  regfile_wb_arb_if if0();

  assign if1.a_valid = av; assign if1.a_sel = as_; assign if1.a_data = ad;
  assign if1.b_valid = bv; assign if1.b_sel = bs;  assign if1.b_data = bd;
  assign if0.a_valid = av; assign if0.a_sel = as_; assign if0.a_data = ad;
  assign if0.b_valid = bv; assign if0.b_sel = bs;  assign if0.b_data = bd;

  regfile_wb_arb #(.INIT_CLEAR(1'b1)) dut1 (.clock(clock), .reset(reset), .wb(if1));
  regfile_wb_arb #(.INIT_CLEAR(1'b0)) dut0 (.clock(clock), .reset(reset), .wb(if0));

  wire        m_ar   = use0 ? if0.a_ready    : if1.a_ready;
  wire        m_br   = use0 ? if0.b_ready    : if1.b_ready;
  wire        m_done = use0 ? if0.init_done  : if1.init_done;
  wire        m_wen  = use0 ? if0.wEn        : if1.wEn;
  wire [4:0]  m_sel  = use0 ? if0.write_sel  : if1.write_sel;
  wire [31:0] m_data = use0 ? if0.write_data : if1.write_data;

  typedef struct { logic ar; logic br; logic done; } rdy_t;
  typedef struct { logic wen; logic [4:0] sel; logic [31:0] data; } wr_t;
  rdy_t rq[$];
  wr_t  wq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, ".a_ready"}, m_ar, 0);
    chk({nm, ".b_ready"}, m_br, 0);
    chk({nm, ".init_done"}, m_done, 0);
    chk({nm, ".wEn"}, m_wen, 0);
    chk({nm, ".write_sel"}, m_sel, 0);
    chk({nm, ".write_data"}, m_data, 0);
  endtask

  // Reference model: sweep counter, favoured side, last written port values.
  bit          r_sweep;
  int          r_idx;
  bit          r_favB;
  logic [4:0]  r_sel;
  logic [31:0] r_data;

  task automatic model_reset();
    r_sweep = !use0;
    r_idx   = 1;
    r_favB  = 1'b0;
    r_sel   = '0;
    r_data  = '0;
  endtask

  task automatic cyc(input logic va, input logic [4:0] sa, input logic [31:0] da,
                     input logic vb, input logic [4:0] sb, input logic [31:0] db,
                     output logic ga, output logic gb);
    rdy_t r;
    wr_t  w;
    av = va; as_ = sa; ad = da;
    bv = vb; bs = sb;  bd = db;
    ga = 1'b0; gb = 1'b0;
    if (r_sweep) begin
      r = '{1'b0, 1'b0, 1'b0};
      w = '{1'b1, r_idx[4:0], 32'd0};
      r_idx++;
      if (r_idx == 32) r_sweep = 1'b0;
    end else begin
      if (va && vb) begin ga = !r_favB; gb = r_favB; end
      else begin ga = va; gb = vb; end
      r = '{ga, gb, 1'b1};
      if (ga || gb) begin
        r_sel  = ga ? sa : sb;
        r_data = ga ? da : db;
        r_favB = ga;
        w = '{(r_sel != 5'd0), r_sel, r_data};
      end else begin
        w = '{1'b0, r_sel, r_data};
      end
    end
    rq.push_back(r);
    wq.push_back(w);
    @(negedge clock);
  endtask

  // Monitors: handshake checked mid-low-phase, write port just after the edge.
  initial forever begin
    @(negedge clock);
    #2;
    if (rq.size() > 0) begin
      rdy_t e;
      e = rq.pop_front();
      chk("a_ready", m_ar, e.ar);
      chk("b_ready", m_br, e.br);
      chk("init_done", m_done, e.done);
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (wq.size() > 0) begin
      wr_t e;
      e = wq.pop_front();
      chk("wEn", m_wen, e.wen);
      chk("write_sel", m_sel, e.sel);
      chk("write_data", m_data, e.data);
    end
  end

  // Requester rule: a stalled request must stay asserted and stable.
  logic        pa_q = 1'b0, pb_q = 1'b0;
  logic [4:0]  sa_q, sb_q;
  logic [31:0] da_q, db_q;
  always @(posedge clock) begin
    if (reset) begin
      if (pa_q) assert (av && as_ == sa_q && ad == da_q) else $error("requester rule broken on A");
      if (pb_q) assert (bv && bs == sb_q && bd == db_q) else $error("requester rule broken on B");
    end
    pa_q <= reset && av && !m_ar;
    pb_q <= reset && bv && !m_br;
    sa_q <= as_; da_q <= ad;
    sb_q <= bs;  db_q <= bd;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ga, gb;
    logic pa, pb;
    logic       rav, rbv;
    logic [4:0] ras, rbs;
    logic [31:0] rad, rbd;
    av = 0; bv = 0; as_ = 0; bs = 0; ad = 0; bd = 0;
    model_reset();
    repeat (2) @(negedge clock);
    av = 1; bv = 1;
    #1 chk_zero("reset");
    @(negedge clock);

    // Sweep with both requesters waiting, then first grant to A
    reset = 1'b1;
    model_reset();
    repeat (31) cyc(1, 5'd9, 32'hA1, 1, 5'd10, 32'hB1, ga, gb);
    cyc(1, 5'd9, 32'hA1, 1, 5'd10, 32'hB1, ga, gb);
    cyc(1, 5'd5, 32'h11, 1, 5'd10, 32'hB1, ga, gb);

    // Contention: A,B,A,B then drain A
    repeat (4) cyc(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, ga, gb);
    cyc(1, 5'd5, 32'h11, 0, 5'd0, 32'h0, ga, gb);

    // x0 drop from B, then prio must favour A
    cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD, ga, gb);
    cyc(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, ga, gb);
    cyc(0, 5'd0, 32'h0, 1, 5'd8, 32'h88, ga, gb);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ga, gb);

    // Single requester A x3, then prio must favour B
    for (int i = 0; i < 3; i++) cyc(1, 5'(i + 3), 32'(i + 100), 0, 5'd0, 32'h0, ga, gb);
    cyc(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, ga, gb);
    cyc(1, 5'd1, 32'h1, 0, 5'd0, 32'h0, ga, gb);

    // Random traffic obeying the requester rule
    pa = 0; pb = 0;
    rav = 0; rbv = 0; ras = 0; rbs = 0; rad = 0; rbd = 0;
    for (int i = 0; i < 300 || pa || pb; i++) begin
      if (!pa) begin
        rav = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
        ras = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rad = $urandom;
      end
      if (!pb) begin
        rbv = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
        rbs = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rbd = $urandom;
      end
      cyc(rav, ras, rad, rbv, rbs, rbd, ga, gb);
      pa = rav && !ga;
      pb = rbv && !gb;
    end
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ga, gb);

    // Reset mid-sweep at index 12
    reset = 1'b0;
    #1 chk_zero("reset2");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (11) cyc(1, 5'd9, 32'hA1, 1, 5'd10, 32'hB1, ga, gb);
    #1 reset = 1'b0;
    #1 chk_zero("midsweep_async");
    @(posedge clock);
    #1 chk_zero("midsweep_held");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (31) cyc(1, 5'd9, 32'hA1, 1, 5'd10, 32'hB1, ga, gb);
    cyc(1, 5'd9, 32'hA1, 1, 5'd10, 32'hB1, ga, gb);
    cyc(0, 5'd0, 32'h0, 1, 5'd10, 32'hB1, ga, gb);

    // INIT_CLEAR=0 instance
    reset = 1'b0;
    use0 = 1'b1;
    av = 0; bv = 0;
    #1 chk_zero("reset0");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1 chk("init_done_immediate", m_done, 1);
    cyc(1, 5'd3, 32'h7, 0, 5'd0, 32'h0, ga, gb);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ga, gb);

    // Reset mid-transfer: pending A must not be written
    av = 1; as_ = 5'd7; ad = 32'h55; bv = 0;
    #1 chk("pending_a_ready", m_ar, 1);
    #1 reset = 1'b0;
    #1 chk_zero("midxfer_async");
    @(posedge clock);
    #1 chk_zero("midxfer_held");
    @(negedge clock);
    av = 0;
    reset = 1'b1;
    model_reset();
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ga, gb);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ga, gb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
